// File: rtl/alu_pkg.sv
// Shared definitions for the ALU dispatch front-end: opcode encodings,
// dispatcher FSM states, the command FIFO payload and opcode classification.
package alu_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned OP_W   = 4;
    localparam int unsigned CMD_W  = OP_W + 2 * DATA_W;

    localparam logic [OP_W-1:0] OP_ADD  = 4'b0000;
    localparam logic [OP_W-1:0] OP_SUB  = 4'b0001;
    localparam logic [OP_W-1:0] OP_AND  = 4'b0010;
    localparam logic [OP_W-1:0] OP_OR   = 4'b0011;
    localparam logic [OP_W-1:0] OP_XOR  = 4'b0100;
    localparam logic [OP_W-1:0] OP_NAND = 4'b0101;
    localparam logic [OP_W-1:0] OP_NOR  = 4'b0110;
    localparam logic [OP_W-1:0] OP_XNOR = 4'b0111;
    localparam logic [OP_W-1:0] OP_MUL  = 4'b1000;
    localparam logic [OP_W-1:0] OP_DIV  = 4'b1001;

    typedef enum logic [2:0] {
        ST_OFF,
        ST_PWR_UP,
        ST_ON_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP,
        ST_PD_ISO
    } state_t;

    // One buffered request: 4-bit opcode + two 16-bit operands (36 bits).
    typedef struct packed {
        logic [OP_W-1:0]   opcode;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } cmd_t;

    // MUL and DIV complete on the falling edge of alu_busy; all others in one cycle.
    function automatic logic is_multicycle(input logic [OP_W-1:0] opcode);
        return (opcode == OP_MUL) || (opcode == OP_DIV);
    endfunction

endpackage

// File: rtl/alu_dispatch_if.sv
// Request/response handshake bundle of the ALU dispatcher.
//   cmd_*: request side (valid/ready), opcode and operands
//   rsp_*: response side (valid/ready), result data and watchdog error flag
// slave = dispatcher side, master = requester side.
interface alu_dispatch_if;
    import alu_pkg::*;

    logic              cmd_valid;
    logic              cmd_ready;
    logic [OP_W-1:0]   cmd_opcode;
    logic [DATA_W-1:0] cmd_a;
    logic [DATA_W-1:0] cmd_b;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;

    modport slave (
        input  cmd_valid, cmd_opcode, cmd_a, cmd_b, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_err
    );

    modport master (
        output cmd_valid, cmd_opcode, cmd_a, cmd_b, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_err
    );

endinterface

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO of cmd_t entries.
//   clk, rst_n : clock, async active-low reset (empties the FIFO)
//   push/wdata : write one entry (caller guarantees !full_c)
//   pop/rdata  : rdata always shows the head; pop advances it (caller guarantees !empty_c)
//   full_c, empty_c : status decoded from the pointer registers
module alu_cmd_fifo
    import alu_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  cmd_t wdata,
    input  logic pop,
    output cmd_t rdata,
    output logic full_c,
    output logic empty_c
);

    localparam int unsigned AW = $clog2(DEPTH);

    cmd_t          mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;

    // Pointers carry one extra wrap bit to tell full from empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + (AW + 1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (AW + 1)'(1);
            end
        end
    end

    // Storage needs no reset; the pointers alone define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= wdata;
        end
    end

    assign rdata   = mem[rd_ptr[AW-1:0]];
    assign empty_c = (wr_ptr == rd_ptr);
    assign full_c  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/alu_dispatch.sv
// Command front-end for the power-gated 16-bit ALU: buffers requests,
// sequences ALU power and isolation, issues one request at a time with a
// single-cycle start pulse and returns the result on a valid/ready port.
//   clk, rst_n              : clock, async active-low reset
//   bus (slave)             : cmd_* request and rsp_* response handshakes
//   alu_pwr_en, iso_en      : ALU power enable / isolation enable (registered)
//   alu_A, alu_B, alu_opcode: operands and opcode held for the issued request
//   alu_start               : one-cycle issue pulse
//   alu_result, alu_busy    : ALU result and busy status
module alu_dispatch
    import alu_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned PWRUP_CYC    = 3,
    parameter int unsigned IDLE_TIMEOUT = 16,
    parameter int unsigned WAIT_LIMIT   = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_dispatch_if.slave      bus,
    output logic               alu_pwr_en,
    output logic               iso_en,
    output logic [DATA_W-1:0]  alu_A,
    output logic [DATA_W-1:0]  alu_B,
    output logic [OP_W-1:0]    alu_opcode,
    output logic               alu_start,
    input  logic [DATA_W-1:0]  alu_result,
    input  logic               alu_busy
);

    localparam int unsigned CNT_MAX0 = (PWRUP_CYC > IDLE_TIMEOUT) ? PWRUP_CYC : IDLE_TIMEOUT;
    localparam int unsigned CNT_MAX  = (CNT_MAX0 > WAIT_LIMIT) ? CNT_MAX0 : WAIT_LIMIT;
    localparam int unsigned CNT_W    = $clog2(CNT_MAX + 1);

    state_t             state;
    state_t             state_nx;
    logic [CNT_W-1:0]   cnt;
    logic               busy_seen;
    logic               wait_done_c;
    logic               wdog_c;

    cmd_t               push_data;
    cmd_t               head;
    logic               push_c;
    logic               pop_c;
    logic               fifo_full_c;
    logic               fifo_empty_c;

    logic               rsp_valid_q;
    logic [DATA_W-1:0]  rsp_data_q;
    logic               rsp_err_q;

    // Command FIFO: pushes accepted in any state, pops only in ISSUE.
    always_comb begin
        push_data        = '0;
        push_data.opcode = bus.cmd_opcode;
        push_data.a      = bus.cmd_a;
        push_data.b      = bus.cmd_b;
    end

    assign push_c        = bus.cmd_valid && !fifo_full_c;
    assign pop_c         = (state == ST_ISSUE);
    assign bus.cmd_ready = !fifo_full_c;

    alu_cmd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push_c),
        .wdata   (push_data),
        .pop     (pop_c),
        .rdata   (head),
        .full_c  (fifo_full_c),
        .empty_c (fifo_empty_c)
    );

    // Next-state logic.
    always_comb begin
        state_nx    = state;
        wait_done_c = 1'b0;
        wdog_c      = 1'b0;
        case (state)
            ST_OFF: begin
                // A push in the same cycle already starts power-up.
                if (!fifo_empty_c || push_c) begin
                    state_nx = ST_PWR_UP;
                end
            end
            ST_PWR_UP: begin
                if (cnt == CNT_W'(PWRUP_CYC - 1)) begin
                    state_nx = ST_ON_IDLE;
                end
            end
            ST_ON_IDLE: begin
                if (!fifo_empty_c) begin
                    state_nx = ST_ISSUE;
                end else if (cnt == CNT_W'(IDLE_TIMEOUT - 1)) begin
                    state_nx = ST_PD_ISO;
                end
            end
            ST_ISSUE: begin
                state_nx = ST_WAIT;
            end
            ST_WAIT: begin
                // Multi-cycle ops finish once busy has been seen and dropped;
                // others finish the first WAIT cycle after the start pulse.
                if (is_multicycle(alu_opcode)) begin
                    wait_done_c = !alu_busy && busy_seen;
                end else begin
                    wait_done_c = !alu_start;
                end
                if (wait_done_c) begin
                    state_nx = ST_RESP;
                end else if (cnt == CNT_W'(WAIT_LIMIT - 1)) begin
                    wdog_c   = 1'b1;
                    state_nx = ST_RESP;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_nx = ST_ON_IDLE;
                end
            end
            ST_PD_ISO: begin
                state_nx = ST_OFF;
            end
            default: begin
                state_nx = ST_OFF;
            end
        endcase
    end

    // State, counters and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_OFF;
            cnt         <= '0;
            busy_seen   <= 1'b0;
            alu_pwr_en  <= 1'b0;
            iso_en      <= 1'b1;
            alu_start   <= 1'b0;
            alu_A       <= '0;
            alu_B       <= '0;
            alu_opcode  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state <= state_nx;

            // One shared counter, restarted on every state change, saturating.
            if (state_nx != state) begin
                cnt <= '0;
            end else if (cnt != {CNT_W{1'b1}}) begin
                cnt <= cnt + CNT_W'(1);
            end

            // Power controls decoded from the next state so they are pure flops.
            alu_pwr_en <= (state_nx != ST_OFF);
            iso_en     <= (state_nx == ST_OFF) || (state_nx == ST_PWR_UP) ||
                          (state_nx == ST_PD_ISO);

            alu_start <= (state == ST_ISSUE);

            if (state == ST_ISSUE) begin
                alu_A      <= head.a;
                alu_B      <= head.b;
                alu_opcode <= head.opcode;
                busy_seen  <= 1'b0;
            end else if (state == ST_WAIT && alu_busy) begin
                busy_seen <= 1'b1;
            end

            if (state == ST_WAIT && state_nx == ST_RESP) begin
                rsp_data_q <= wdog_c ? '0 : alu_result;
                rsp_err_q  <= wdog_c;
            end

            rsp_valid_q <= (state_nx == ST_RESP);
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_alu_dispatch.sv
// Self-checking bench for alu_dispatch with a behavioural ALU model.
module tb_alu_dispatch;
    import alu_pkg::*;

    localparam int unsigned PWRUP_CYC = 3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    alu_dispatch_if bus();

    logic        alu_pwr_en, iso_en, alu_start, alu_busy;
    logic [15:0] alu_A, alu_B, alu_result;
    logic [3:0]  alu_opcode;

    alu_dispatch #(
        .FIFO_DEPTH   (4),
        .PWRUP_CYC    (PWRUP_CYC),
        .IDLE_TIMEOUT (16),
        .WAIT_LIMIT   (15)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .alu_pwr_en (alu_pwr_en),
        .iso_en     (iso_en),
        .alu_A      (alu_A),
        .alu_B      (alu_B),
        .alu_opcode (alu_opcode),
        .alu_start  (alu_start),
        .alu_result (alu_result),
        .alu_busy   (alu_busy)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    // ALU model: MUL busy 5 cycles, DIV busy 9 cycles, others combinational-ish.
    logic stuck;
    logic busy_r;
    int   busy_left;

    function automatic logic [15:0] alu_fn(input logic [3:0] op, input logic [15:0] a,
                                           input logic [15:0] b);
        logic [31:0] p;
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_NAND: return ~(a & b);
            OP_NOR:  return ~(a | b);
            OP_XNOR: return ~(a ^ b);
            OP_MUL: begin
                p = 32'(a) * 32'(b);
                return p[15:0];
            end
            OP_DIV:  return (b == 16'h0000) ? 16'h0000 : a / b;
            default: return 16'h0000;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r     <= 1'b0;
            busy_left  <= 0;
            alu_result <= 16'h0000;
        end else if (alu_start) begin
            alu_result <= alu_fn(alu_opcode, alu_A, alu_B);
            if (alu_opcode == OP_MUL) begin
                busy_r <= 1'b1; busy_left <= 5;
            end else if (alu_opcode == OP_DIV) begin
                busy_r <= 1'b1; busy_left <= 9;
            end else begin
                busy_r <= 1'b0; busy_left <= 0;
            end
        end else if (busy_left > 0) begin
            busy_left <= busy_left - 1;
            busy_r    <= (busy_left > 1);
        end
    end

    assign alu_busy = busy_r | stuck;

    typedef struct {
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp_data;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check_reset(input string tag);
        check({tag, " pwr_en"},    32'(alu_pwr_en),    0);
        check({tag, " iso_en"},    32'(iso_en),        1);
        check({tag, " alu_start"}, 32'(alu_start),     0);
        check({tag, " alu_A"},     32'(alu_A),         0);
        check({tag, " alu_B"},     32'(alu_B),         0);
        check({tag, " alu_op"},    32'(alu_opcode),    0);
        check({tag, " rsp_valid"}, 32'(bus.rsp_valid), 0);
        check({tag, " rsp_data"},  32'(bus.rsp_data),  0);
        check({tag, " rsp_err"},   32'(bus.rsp_err),   0);
        check({tag, " cmd_ready"}, 32'(bus.cmd_ready), 1);
    endtask

    task automatic push(input vec_t v);
        int guard = 0;
        while (!bus.cmd_ready && guard < 200) begin
            tick();
            guard++;
        end
        if (!bus.cmd_ready) begin
            check("push_ready_timeout", 32'(bus.cmd_ready), 1);
            return;
        end
        bus.cmd_valid  = 1'b1;
        bus.cmd_opcode = v.op;
        bus.cmd_a      = v.a;
        bus.cmd_b      = v.b;
        tick();
        bus.cmd_valid  = 1'b0;
    endtask

    // Wait for the issue of v, check operands, pulse, latency and response; accept it.
    task automatic finish_cmd(input vec_t v, input string tag, output int t_start, output int t_hs);
        int   guard = 0;
        logic stable = 1'b1;
        logic extra  = 1'b0;
        t_start = -1;
        t_hs    = -1;
        while (!alu_start && guard < 100) begin
            tick();
            guard++;
        end
        check({tag, " start_seen"}, 32'(alu_start), 1);
        if (!alu_start) return;
        t_start = cyc;
        check({tag, " alu_op"}, 32'(alu_opcode), 32'(v.op));
        check({tag, " alu_A"},  32'(alu_A),      32'(v.a));
        check({tag, " alu_B"},  32'(alu_B),      32'(v.b));
        tick();
        guard = 0;
        while (!bus.rsp_valid && guard < 100) begin
            if (alu_A !== v.a || alu_B !== v.b || alu_opcode !== v.op) stable = 1'b0;
            if (alu_start) extra = 1'b1;
            tick();
            guard++;
        end
        check({tag, " operands_stable"}, 32'(stable), 1);
        check({tag, " start_single"},    32'(extra),  0);
        check({tag, " rsp_valid"},       32'(bus.rsp_valid), 1);
        if (!bus.rsp_valid) return;
        check({tag, " latency"},  32'(cyc - t_start),  32'(v.exp_lat));
        check({tag, " rsp_data"}, 32'(bus.rsp_data),   32'(v.exp_data));
        check({tag, " rsp_err"},  32'(bus.rsp_err),    32'(v.exp_err));
        t_hs = cyc;
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        check({tag, " rsp_drop"}, 32'(bus.rsp_valid), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tbl [9];
        vec_t ff  [5];
        vec_t v, v2;
        int   c0, ts, th, ts2, th2, guard;

        tbl[0] = '{OP_MUL,  16'h0012, 16'h0003, 16'h0036, 1'b0, 7};
        tbl[1] = '{OP_DIV,  16'h0064, 16'h0000, 16'h0000, 1'b0, 11};
        tbl[2] = '{OP_DIV,  16'h0064, 16'h0007, 16'h000E, 1'b0, 11};
        tbl[3] = '{OP_SUB,  16'h0000, 16'h0001, 16'hFFFF, 1'b0, 2};
        tbl[4] = '{OP_XOR,  16'hA5A5, 16'h0FF0, 16'hAA55, 1'b0, 2};
        tbl[5] = '{OP_NAND, 16'hFFFF, 16'h00FF, 16'hFF00, 1'b0, 2};
        tbl[6] = '{OP_XNOR, 16'h1234, 16'h1234, 16'hFFFF, 1'b0, 2};
        tbl[7] = '{OP_MUL,  16'h0100, 16'h0100, 16'h0000, 1'b0, 7};
        tbl[8] = '{OP_OR,   16'h8000, 16'h0001, 16'h8001, 1'b0, 2};

        ff[0] = '{OP_ADD, 16'h0001, 16'h0001, 16'h0002, 1'b0, 2};
        ff[1] = '{OP_SUB, 16'h0010, 16'h0001, 16'h000F, 1'b0, 2};
        ff[2] = '{OP_AND, 16'hF0F0, 16'h0FF0, 16'h00F0, 1'b0, 2};
        ff[3] = '{OP_NOR, 16'h00FF, 16'h0F00, 16'hF000, 1'b0, 2};
        ff[4] = '{OP_ADD, 16'hFFFF, 16'h0002, 16'h0001, 1'b0, 2};

        rst_n          = 1'b0;
        stuck          = 1'b0;
        bus.cmd_valid  = 1'b0;
        bus.cmd_opcode = 4'h0;
        bus.cmd_a      = 16'h0000;
        bus.cmd_b      = 16'h0000;
        bus.rsp_ready  = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        check_reset("reset");

        // Cold ADD: power-up sequence then a single-cycle op.
        v  = '{OP_ADD, 16'h0003, 16'h0004, 16'h0007, 1'b0, 2};
        c0 = cyc;
        bus.cmd_valid  = 1'b1;
        bus.cmd_opcode = v.op;
        bus.cmd_a      = v.a;
        bus.cmd_b      = v.b;
        tick();
        bus.cmd_valid  = 1'b0;
        check("cold pwr_en_c1", 32'(alu_pwr_en), 1);
        check("cold iso_c1",    32'(iso_en),     1);
        tick(); tick();
        check("cold iso_c3",    32'(iso_en),     1);
        tick();
        check("cold iso_c4",    32'(iso_en),     0);
        check("cold pwr_en_c4", 32'(alu_pwr_en), 1);
        finish_cmd(v, "cold", ts, th);
        check("cold start_cycle", 32'(ts - c0), 32'(PWRUP_CYC + 3));

        // Warm directed vectors.
        for (int i = 0; i < 9; i++) begin
            push(tbl[i]);
            finish_cmd(tbl[i], $sformatf("vec%0d", i), ts, th);
        end

        // Back-to-back: handshake -> start of queued command is 3 cycles later.
        v  = '{OP_ADD, 16'h1111, 16'h2222, 16'h3333, 1'b0, 2};
        v2 = '{OP_AND, 16'hFF00, 16'h0F0F, 16'h0F00, 1'b0, 2};
        push(v);
        push(v2);
        finish_cmd(v,  "b2b0", ts,  th);
        finish_cmd(v2, "b2b1", ts2, th2);
        check("b2b gap", 32'(ts2 - th), 3);

        // Idle power-down with a push during PD_ISO.
        repeat (15) tick();
        check("pd iso_idle16",    32'(iso_en),     0);
        check("pd pwr_idle16",    32'(alu_pwr_en), 1);
        tick();
        check("pd iso_pdiso",     32'(iso_en),     1);
        check("pd pwr_pdiso",     32'(alu_pwr_en), 1);
        v = '{OP_XOR, 16'h00FF, 16'hFFFF, 16'hFF00, 1'b0, 2};
        bus.cmd_valid  = 1'b1;
        bus.cmd_opcode = v.op;
        bus.cmd_a      = v.a;
        bus.cmd_b      = v.b;
        tick();
        bus.cmd_valid  = 1'b0;
        check("pd pwr_off",       32'(alu_pwr_en), 0);
        check("pd iso_off",       32'(iso_en),     1);
        tick();
        check("pd pwr_repower",   32'(alu_pwr_en), 1);
        check("pd iso_repower",   32'(iso_en),     1);
        finish_cmd(v, "pd", ts, th);

        // Watchdog on a MUL whose busy never drops.
        stuck = 1'b1;
        v = '{OP_MUL, 16'h0002, 16'h0003, 16'h0000, 1'b1, 15};
        push(v);
        finish_cmd(v, "wdog", ts, th);
        stuck = 1'b0;
        v = '{OP_ADD, 16'h0005, 16'h0005, 16'h000A, 1'b0, 2};
        push(v);
        finish_cmd(v, "post_wdog", ts, th);

        // Full FIFO with stalled responses.
        for (int i = 0; i < 5; i++) push(ff[i]);
        tick();
        check("full cmd_ready", 32'(bus.cmd_ready), 0);
        for (int i = 0; i < 5; i++) begin
            guard = 0;
            while (!bus.rsp_valid && guard < 200) begin
                tick();
                guard++;
            end
            check($sformatf("full%0d rsp_valid", i), 32'(bus.rsp_valid), 1);
            check($sformatf("full%0d rsp_data", i),  32'(bus.rsp_data),  32'(ff[i].exp_data));
            check($sformatf("full%0d rsp_err", i),   32'(bus.rsp_err),   0);
            bus.rsp_ready = 1'b1;
            tick();
            bus.rsp_ready = 1'b0;
        end
        check("full drained ready", 32'(bus.cmd_ready), 1);

        // Asynchronous reset in the middle of a DIV with a command still queued.
        v  = '{OP_DIV, 16'h0064, 16'h0005, 16'h0014, 1'b0, 11};
        v2 = '{OP_ADD, 16'h0001, 16'h0001, 16'h0002, 1'b0, 2};
        push(v);
        push(v2);
        guard = 0;
        while (!alu_start && guard < 100) begin
            tick();
            guard++;
        end
        check("rst start_seen", 32'(alu_start), 1);
        repeat (3) tick();
        #2 rst_n = 1'b0;
        #1 check_reset("rst_async");
        tick();
        rst_n = 1'b1;
        repeat (10) tick();
        check("rst fifo_empty_off", 32'(alu_pwr_en),    0);
        check("rst no_rsp",         32'(bus.rsp_valid), 0);
        v = '{OP_ADD, 16'h0001, 16'h0002, 16'h0003, 1'b0, 2};
        push(v);
        finish_cmd(v, "post_rst", ts, th);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
